divider_ctrl: RTL and testbench

DIVIDER_CTRL -- requirements
Module: divider_ctrl

---
 rtl/divider_ctrl.sv | 113 +++++++++++
 tb/tb_divider_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_ctrl.sv
// Programmable clock-enable divider: one-cycle y pulse every div_r cycles, with
// run/pause/idle sequencing, ratio configuration and a sticky error state.
module divider_ctrl #(
  parameter int DIV_W     = 4,
  parameter int RESET_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             y,
  output logic [1:0]       state,
  output logic [7:0]       period_cnt,
  output logic             err
);

  // state | meaning
  // IDLE  | stopped, ratio may be configured, start begins a fresh count
  // RUN   | dividing, y pulses when ph==0, configuration locked out
  // PAUSE | frozen mid-period, ph and period_cnt held, ratio may be changed
  // ERR   | last offered ratio was below 2, waits for a valid ratio
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_ERR   = 2'b11
  } state_t;

  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] ph_q, ph_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             cfg_acc;
  logic             cfg_ok;
  logic             ph_last;

  assign cfg_acc = cfg_valid && (state_q != ST_RUN);
  assign cfg_ok  = (cfg_div >= MIN_DIV);
  assign ph_last = (ph_q == div_q - 1'b1);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    if (cfg_acc) begin
      // an accepted cfg consumes the cycle: start/stop are ignored
      if (cfg_ok) begin
        div_d = cfg_div;
        if (state_q == ST_ERR) state_d = ST_IDLE;
      end else begin
        state_d = ST_ERR;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!stop && start) begin
            state_d = ST_RUN;
            ph_d    = '0;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (ph_last) begin
            ph_d  = '0;
            cnt_d = cnt_q + 8'd1;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (start) begin
            state_d = ST_RUN;
            // ratio may have shrunk below the held phase while paused
            if (ph_q >= div_q) ph_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      div_q   <= RST_DIV;
      ph_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cfg_ready  = (state_q != ST_RUN);
  assign y          = (state_q == ST_RUN) && (ph_q == '0);
  assign err        = (state_q == ST_ERR);
  assign state      = state_q;
  assign period_cnt = cnt_q;

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl: directed scenarios plus random
// stimulus, all compared against a cycle-level behavioural model.
module tb_divider_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic [3:0] cfg_div;
  logic       cfg_ready;
  logic       start;
  logic       stop;
  logic       y;
  logic [1:0] state;
  logic [7:0] period_cnt;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  divider_ctrl #(.DIV_W(4), .RESET_DIV(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .start      (start),
    .stop       (stop),
    .y          (y),
    .state      (state),
    .period_cnt (period_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  // model: mode name, ratio, position within period, completed periods
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ERR = 3;
  int m_mode, m_div, m_pos, m_periods;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int exp_code(input int mode);
    case (mode)
      M_RUN:   return 1;
      M_PAUSE: return 2;
      M_ERR:   return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_div = 3; m_pos = 0; m_periods = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit st, input bit sp);
    if (v && m_mode != M_RUN) begin
      if (d >= 2) begin
        m_div = d;
        if (m_mode == M_ERR) m_mode = M_IDLE;
      end else m_mode = M_ERR;
    end else if (m_mode == M_IDLE) begin
      if (!sp && st) begin m_mode = M_RUN; m_pos = 0; m_periods = 0; end
    end else if (m_mode == M_RUN) begin
      if (sp) m_mode = M_PAUSE;
      else begin
        m_pos = m_pos + 1;
        if (m_pos >= m_div) begin m_pos = 0; m_periods = (m_periods + 1) % 256; end
      end
    end else if (m_mode == M_PAUSE) begin
      if (sp) m_mode = M_IDLE;
      else if (st) begin m_mode = M_RUN; if (m_pos >= m_div) m_pos = 0; end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".state"}, int'(state), exp_code(m_mode));
    check({tag, ".y"}, int'(y), (m_mode == M_RUN && m_pos == 0) ? 1 : 0);
    check({tag, ".period_cnt"}, int'(period_cnt), m_periods);
    check({tag, ".err"}, int'(err), (m_mode == M_ERR) ? 1 : 0);
    check({tag, ".cfg_ready"}, int'(cfg_ready), (m_mode == M_RUN) ? 0 : 1);
  endtask

  // called at posedge+1: drive, check current outputs, clock, advance model
  task automatic tick(input string tag, input bit v, input int d, input bit st, input bit sp);
    cfg_valid = v; cfg_div = 4'(d); start = st; stop = sp;
    check_outputs(tag);
    @(posedge clk);
    model_step(v, d, st, sp);
    #1;
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, ".rst_state"}, int'(state), 0);
    check({tag, ".rst_y"}, int'(y), 0);
    check({tag, ".rst_cnt"}, int'(period_cnt), 0);
    check({tag, ".rst_err"}, int'(err), 0);
    check({tag, ".rst_ready"}, int'(cfg_ready), 1);
    model_reset();
    @(posedge clk); #1;
    check({tag, ".held_state"}, int'(state), 0);
    reset = 1'b1;
  endtask

  int y_pat[6] = '{1, 0, 0, 1, 0, 0};
  int pulses;

  initial begin
    reset = 1'b0; cfg_valid = 1'b0; cfg_div = '0; start = 1'b0; stop = 1'b0;
    model_reset();
    #1;
    check("reset.state", int'(state), 0);
    check("reset.ready", int'(cfg_ready), 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // default ratio 3 straight out of reset
    tick("n3.start", 0, 0, 1, 0);
    check("n3.state_run", int'(state), 1);
    for (int i = 0; i < 6; i++) begin
      check("n3.ypat", int'(y), y_pat[i]);
      tick("n3.run", 0, 0, 0, 0);
    end
    check("n3.cnt2", int'(period_cnt), 2);

    // ratio 5, cfg refused while running
    tick("n5.stop1", 0, 0, 0, 1);
    tick("n5.stop2", 0, 0, 0, 1);
    check("n5.ready_idle", int'(cfg_ready), 1);
    tick("n5.cfg", 1, 5, 0, 0);
    tick("n5.start", 0, 0, 1, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      pulses += int'(y);
      tick("n5.run", (i == 3), 7, 0, 0);
      if (i == 3) check("n5.ready_run", int'(cfg_ready), 0);
    end
    check("n5.pulses", pulses, 2);
    check("n5.model_div", m_div, 5);

    // bad ratio -> ERR, start ignored, valid ratio recovers
    tick("err.stop", 0, 0, 0, 1);
    tick("err.stop2", 0, 0, 0, 1);
    tick("err.bad", 1, 1, 0, 0);
    check("err.state", int'(state), 3);
    check("err.flag", int'(err), 1);
    tick("err.start", 0, 0, 1, 0);
    check("err.still", int'(state), 3);
    tick("err.fix", 1, 4, 0, 0);
    check("err.idle", int'(state), 0);
    check("err.clear", int'(err), 0);

    // N=4, pause at ph=2, resume
    tick("pz.start", 0, 0, 1, 0);
    tick("pz.ph0", 0, 0, 0, 0);
    tick("pz.ph1", 0, 0, 0, 0);
    tick("pz.stop", 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      check("pz.y_hold", int'(y), 0);
      tick("pz.hold", 0, 0, 0, 0);
    end
    tick("pz.resume", 0, 0, 1, 0);
    check("pz.ph2_y", int'(y), 0);
    tick("pz.ph2", 0, 0, 0, 0);
    check("pz.ph3_y", int'(y), 0);
    tick("pz.ph3", 0, 0, 0, 0);
    check("pz.ph0_y", int'(y), 1);
    check("pz.cnt", int'(period_cnt), 1);

    // shrink ratio while paused below held phase
    tick("sh.run", 0, 0, 0, 0);
    tick("sh.run2", 0, 0, 0, 0);
    tick("sh.stop", 0, 0, 0, 1);
    tick("sh.cfg", 1, 2, 0, 0);
    tick("sh.resume", 0, 0, 1, 0);
    check("sh.y", int'(y), 1);

    // start+stop together in IDLE, then async reset mid-run
    tick("ss.stop", 0, 0, 0, 1);
    tick("ss.stop2", 0, 0, 0, 1);
    tick("ss.both", 0, 0, 1, 1);
    check("ss.idle", int'(state), 0);
    tick("ar.start", 0, 0, 1, 0);
    tick("ar.run", 0, 0, 0, 0);
    async_reset("ar");
    tick("ar.restart", 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      check("ar.ypat", int'(y), y_pat[i]);
      tick("ar.run3", 0, 0, 0, 0);
    end

    // N=2 for 512 cycles: period counter wraps
    tick("wr.stop", 0, 0, 0, 1);
    tick("wr.stop2", 0, 0, 0, 1);
    tick("wr.cfg", 1, 2, 0, 0);
    tick("wr.start", 0, 0, 1, 0);
    for (int i = 0; i < 512; i++) tick("wr.run", 0, 0, 0, 0);
    check("wr.cnt", int'(period_cnt), 0);
    tick("wr.run1", 0, 0, 0, 0);
    tick("wr.run2", 0, 0, 0, 0);
    check("wr.cnt1", int'(period_cnt), 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick("rnd",
           ($urandom_range(7) == 0),
           int'($urandom_range(15)),
           ($urandom_range(3) == 0),
           ($urandom_range(9) == 0));
      if ($urandom_range(499) == 0) async_reset("rnd");
    end
    check_outputs("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
